fifo_push_arbiter: RTL and testbench

- Shares the push port of the 4-entry FIFO between two producers, using round-robin arbitration.
- Keeps a shadow occupancy count, so it never issues a push the FIFO cannot accept.
- Flags a consumer pop of an empty FIFO with a sticky error.
- Sits between producers 0/1 and the FIFO's data_in_valid/data_in inputs; pop_fifo is shared with the FIFO.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 30 +++
 rtl/fifo_push_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// =====================================================================
// fifo_arb_pkg: shared defaults and round-robin index values. Rev 1.0
// =====================================================================
`default_nettype none

package fifo_arb_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int DW_DEFAULT    = 16;
    localparam int CW_DEFAULT    = 3;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// =====================================================================
// rr_arb2: combinational two-way round-robin pick. Rev 1.0
// =====================================================================
`default_nettype none

module rr_arb2
    import fifo_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic en_i,
    input  logic last_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    always_comb begin
        gnt_valid_o = en_i & (req0_i | req1_i);
        gnt_idx_o   = P0;
        // On a tie the producer that did not win last time goes first.
        if (req0_i && req1_i) begin
            gnt_idx_o = (last_i == P0) ? P1 : P0;
        end else if (req1_i) begin
            gnt_idx_o = P1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
// =====================================================================
// fifo_push_arbiter: round-robin sharing of a FIFO push port with a
// shadow occupancy count and sticky empty-pop error. Rev 1.0
// =====================================================================
`default_nettype none

module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic [DW-1:0] data0_i,
    input  logic          req1_i,
    input  logic [DW-1:0] data1_i,
    input  logic          pop_fifo_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          data_in_valid_o,
    output logic [DW-1:0] data_in_o,
    output logic [CW-1:0] occ_o,
    output logic          err_o
);

    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          dv_q, dv_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          err_q, err_d;
    logic          last_q, last_d;

    logic          pop_ok;
    logic [CW:0]   level;
    logic          space;
    logic          gnt_valid;
    logic          gnt_idx;

    // The FIFO silently ignores a pop when empty, so only count real pops.
    assign pop_ok = pop_fifo_i & (occ_q != '0);

    // The registered push still in flight will land this cycle.
    assign level = {1'b0, occ_q} + {{CW{1'b0}}, dv_q} - {{CW{1'b0}}, pop_ok};
    assign space = (level < (CW+1)'(DEPTH));

    rr_arb2 u_rr_arb2 (
        .req0_i      (req0_i),
        .req1_i      (req1_i),
        .en_i        (space),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        dv_d   = 1'b0;
        data_d = data_q;
        last_d = last_q;
        occ_d  = occ_q + {{(CW-1){1'b0}}, dv_q} - {{(CW-1){1'b0}}, pop_ok};
        err_d  = err_q | (pop_fifo_i & (occ_q == '0));
        if (gnt_valid) begin
            dv_d   = 1'b1;
            last_d = gnt_idx;
            if (gnt_idx == P1) begin
                gnt1_d = 1'b1;
                data_d = data1_i;
            end else begin
                gnt0_d = 1'b1;
                data_d = data0_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            dv_q   <= 1'b0;
            data_q <= '0;
            occ_q  <= '0;
            err_q  <= 1'b0;
            last_q <= P1;
        end else begin
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
            dv_q   <= dv_d;
            data_q <= data_d;
            occ_q  <= occ_d;
            err_q  <= err_d;
            last_q <= last_d;
        end
    end

    assign gnt0_o          = gnt0_q;
    assign gnt1_o          = gnt1_q;
    assign data_in_valid_o = dv_q;
    assign data_in_o       = data_q;
    assign occ_o           = occ_q;
    assign err_o           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
// =====================================================================
// tb_fifo_push_arbiter: directed scenarios plus random traffic against
// a behavioural model of the push arbiter. Rev 1.0
// =====================================================================
`default_nettype none

module tb_fifo_push_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, pop = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, dv, err;
    logic [DW-1:0] din;
    logic [CW-1:0] occ;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int            m_occ;
    bit            m_dv, m_g0, m_g1, m_err;
    int            m_last;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req0_i          (req0),
        .data0_i         (data0),
        .req1_i          (req1),
        .data1_i         (data1),
        .pop_fifo_i      (pop),
        .gnt0_o          (gnt0),
        .gnt1_o          (gnt1),
        .data_in_valid_o (dv),
        .data_in_o       (din),
        .occ_o           (occ),
        .err_o           (err)
    );

    task automatic model_reset();
        m_occ = 0; m_dv = 0; m_g0 = 0; m_g1 = 0; m_err = 0; m_last = 1; m_data = '0;
    endtask

    // One clock: model absorbs the inputs seen at the edge, then settle.
    task automatic tick();
        int  popped, winner;
        bool_space: begin end
        @(posedge clk);
        popped = (pop && m_occ > 0) ? 1 : 0;
        if (pop && m_occ == 0) m_err = 1;
        winner = -1;
        if (m_occ + int'(m_dv) - popped < DEPTH) begin
            if (req0 && req1) winner = 1 - m_last;
            else if (req0)    winner = 0;
            else if (req1)    winner = 1;
        end
        m_occ = m_occ + int'(m_dv) - popped;
        m_g0 = (winner == 0);
        m_g1 = (winner == 1);
        m_dv = (winner >= 0);
        if (winner == 0) m_data = data0;
        if (winner == 1) m_data = data1;
        if (winner >= 0) m_last = winner;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req0 = 0; req1 = 0; pop = 0; data0 = '0; data1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({gnt0, gnt1, dv, err} !== 4'b0000 || din !== '0 || occ !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: g0=%b g1=%b dv=%b err=%b din=%h occ=%0d, want all 0",
                     gnt0, gnt1, dv, err, din, occ);
        end
        pop = 1; tick(); pop = 0;
        n_checks++;
        if (err !== 1'b1 || occ !== 3'd0) begin
            n_errors++;
            $display("FAIL empty_pop: err=%b occ=%0d, want err=1 occ=0", err, occ);
        end
        repeat (10) tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req0 = 1; data0 = 16'h00A1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || dv !== 1'b1 || din !== 16'h00A1 + 16'(c)) begin
                n_errors++;
                $display("FAIL single_grant%0d: g0=%b g1=%b dv=%b din=%h, want 1 0 1 %h",
                         c, gnt0, gnt1, dv, din, 16'h00A1 + 16'(c));
            end
            data0 = 16'h00A2 + 16'(c);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (gnt0 !== 1'b0 || dv !== 1'b0) begin
                n_errors++;
                $display("FAIL single_full_hold%0d: g0=%b dv=%b, want 0 0", c, gnt0, dv);
            end
        end
        n_checks++;
        if (occ !== 3'd4) begin
            n_errors++;
            $display("FAIL single_occ: occ=%0d, want 4", occ);
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        req0 = 1; req1 = 1; data0 = 16'($urandom); data1 = 16'($urandom);
        for (int k = 0; k < 24; k++) begin
            logic [DW-1:0] want;
            want = (k % 2 == 0) ? data0 : data1;
            tick();
            n_checks++;
            if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1) || din !== want) begin
                n_errors++;
                $display("FAIL fair_cycle%0d: g0=%b g1=%b din=%h, want g0=%b g1=%b din=%h",
                         k, gnt0, gnt1, din, k % 2 == 0, k % 2 == 1, want);
            end
            if (m_g0) data0 = 16'($urandom);
            if (m_g1) data1 = 16'($urandom);
            if (occ >= 3'd1) pop = 1;
        end
        n_checks++;
        if (occ !== 3'(m_occ) || err !== 1'b0) begin
            n_errors++;
            $display("FAIL fair_occ: occ=%0d err=%b, want occ=%0d err=0", occ, err, m_occ);
        end
        pop = 0;
    endtask

    task automatic test_full_pop();
        apply_reset();
        req1 = 1; data1 = 16'h00B1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (m_g1) data1 = data1 + 16'd1;
        end
        n_checks++;
        if (occ !== 3'd4 || gnt1 !== 1'b0) begin
            n_errors++;
            $display("FAIL full_pre: occ=%0d g1=%b, want 4 0", occ, gnt1);
        end
        pop = 1; tick(); pop = 0;
        n_checks++;
        if (gnt1 !== 1'b1 || din !== 16'h00B5 || occ !== 3'd3) begin
            n_errors++;
            $display("FAIL full_pop_grant: g1=%b din=%h occ=%0d, want 1 00b5 3", gnt1, din, occ);
        end
        data1 = 16'h00B6;
        tick();
        n_checks++;
        if (gnt1 !== 1'b0 || occ !== 3'd4) begin
            n_errors++;
            $display("FAIL full_refill: g1=%b occ=%0d, want 0 4", gnt1, occ);
        end
    endtask

    task automatic test_inflight_pop();
        apply_reset();
        req0 = 1; data0 = 16'h00C1;
        tick();
        req0 = 0; pop = 1;
        n_checks++;
        if (dv !== 1'b1 || occ !== 3'd0) begin
            n_errors++;
            $display("FAIL inflight_pre: dv=%b occ=%0d, want 1 0", dv, occ);
        end
        tick(); pop = 0;
        n_checks++;
        if (err !== 1'b1 || occ !== 3'd1) begin
            n_errors++;
            $display("FAIL inflight_pop: err=%b occ=%0d, want 1 1", err, occ);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req0 = 1; data0 = 16'h00D1;
        repeat (3) begin
            tick();
            if (m_g0) data0 = data0 + 16'd1;
        end
        n_checks++;
        if (occ !== 3'd2 || dv !== 1'b1) begin
            n_errors++;
            $display("FAIL async_pre: occ=%0d dv=%b, want 2 1", occ, dv);
        end
        #2 rst_n = 1'b0; req0 = 0;
        #1;
        model_reset();
        n_checks++;
        if ({gnt0, gnt1, dv, err} !== 4'b0000 || occ !== '0 || din !== '0) begin
            n_errors++;
            $display("FAIL async_clear: g0=%b g1=%b dv=%b err=%b occ=%0d din=%h, want all 0",
                     gnt0, gnt1, dv, err, occ, din);
        end
        @(posedge clk);
        #1 rst_n = 1'b1; req0 = 1; req1 = 1; data0 = 16'h0E00; data1 = 16'h0E01;
        tick();
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || din !== 16'h0E00) begin
            n_errors++;
            $display("FAIL async_first_grant: g0=%b g1=%b din=%h, want 1 0 0e00", gnt0, gnt1, din);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            if (!req0 || m_g0) begin req0 = 1'($urandom); data0 = 16'($urandom); end
            if (!req1 || m_g1) begin req1 = 1'($urandom); data1 = 16'($urandom); end
            pop = ($urandom_range(0, 2) == 0);
            tick();
            n_checks++;
            if (gnt0 !== m_g0 || gnt1 !== m_g1 || dv !== m_dv || din !== m_data ||
                occ !== 3'(m_occ) || err !== m_err) begin
                n_errors++;
                $display("FAIL random_cycle%0d: g0=%b g1=%b dv=%b din=%h occ=%0d err=%b, want %b %b %b %h %0d %b",
                         k, gnt0, gnt1, dv, din, occ, err, m_g0, m_g1, m_dv, m_data, m_occ, m_err);
            end
        end
        pop = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_full_pop();
        test_inflight_pop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
